if_stage: RTL

//   Instruction-fetch stage of the pipelined LA32R core; sits directly upstream of the ID stage.

---
 rtl/cpu_defs.sv | 21 ++
 rtl/if_inst_buf.sv | 33 +++
 rtl/if_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the LA32R pipeline: inter-stage bus widths and the
// architectural constants the fetch stage needs.
package cpu_defs;

    localparam int FS_TO_DS_BUS_WD = 65;
    localparam int BR_BUS_WD       = 33;

    localparam logic [31:0] NOP_INST = 32'h0340_0000;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic        adef;
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry holding register for the fetched word while ID stalls, so the
// synchronous SRAM output may change freely during the stall.
module if_inst_buf
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] rdata,
    output logic        buf_valid,
    output logic [31:0] buf_inst
);

    logic        buf_valid_reg;
    logic [31:0] buf_inst_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_reg <= 1'b0;
            buf_inst_reg  <= 32'd0;
        end else if (clear) begin
            buf_valid_reg <= 1'b0;
        end else if (capture) begin
            buf_valid_reg <= 1'b1;
            buf_inst_reg  <= rdata;
        end
    end

    assign buf_valid = buf_valid_reg;
    assign buf_inst  = buf_inst_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous inst SRAM and
// hands {adef, pc, inst} to ID over a valid/allowin handshake.
module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic                       inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    logic        fs_valid_reg;
    logic        fs_adef_reg;
    logic [31:0] fs_pc_reg;

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic        buf_capture;
    logic        buf_clear;
    logic [31:0] fs_inst;
    fs_to_ds_t   fs_bus;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // pre-IF: choose the next fetch address
    assign seq_pc      = fs_pc_reg + 32'd4;
    assign nextpc      = br_taken ? br_target : seq_pc;
    assign to_fs_valid = ~reset;

    assign fs_ready_go = 1'b1;
    assign fs_allowin  = ~fs_valid_reg | (fs_ready_go & ds_allowin) | br_taken;

    assign inst_sram_en    = to_fs_valid & fs_allowin & ~is_misaligned(nextpc);
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_reg <= 1'b0;
            fs_pc_reg    <= RESET_PC - 32'd4;
            fs_adef_reg  <= 1'b0;
        end else if (fs_allowin) begin
            fs_valid_reg <= to_fs_valid;
            fs_pc_reg    <= nextpc;
            fs_adef_reg  <= is_misaligned(nextpc);
        end
    end

    // A redirect kills the word currently in IF; reset masks the stale fs_valid.
    assign fs_to_ds_valid = fs_valid_reg & ~br_taken & ~reset;

    assign buf_capture = fs_valid_reg & ~buf_valid & ~ds_allowin & ~br_taken;
    assign buf_clear   = (fs_to_ds_valid & ds_allowin) | br_taken;

    if_inst_buf u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .capture   (buf_capture),
        .clear     (buf_clear),
        .rdata     (inst_sram_rdata),
        .buf_valid (buf_valid),
        .buf_inst  (buf_inst)
    );

    assign fs_inst = fs_adef_reg ? NOP_INST : (buf_valid ? buf_inst : inst_sram_rdata);

    assign fs_bus.adef   = fs_adef_reg;
    assign fs_bus.pc     = fs_pc_reg;
    assign fs_bus.inst   = fs_inst;
    assign fs_to_ds_bus  = fs_bus;

endmodule
